// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux between four requesters, with a one-cycle
// disabled handoff on every ownership change. Define MUX_ARB_LOCK_EN to add the lock input.
module mux_rr_arbiter #(
    parameter int SLOT_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef MUX_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic       mux_s1,
    output logic       mux_s0,
    output logic       mux_en_n,
    output logic       busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] HANDOFF = 2'd2;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       sel_q;
    logic [1:0]       last;
    logic [CNT_W-1:0] cnt;

    logic             win_valid;
    logic [1:0]       win_idx;
    logic             owner_req;
    logic             others_pending;
    logic             slot_end;
    logic             locked;

    // Scan starts just past the last owner, so it can only win again when nobody else asks.
    function automatic logic [2:0] find_winner(input logic [3:0] r, input logic [1:0] from);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int k = 1; k < 5; k++) begin
            idx = from + 2'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        {win_valid, win_idx} = find_winner(req, last);
        owner_req      = req[sel_q];
        others_pending = (req & ~(4'b0001 << sel_q)) != 4'b0000;
        slot_end       = (cnt == SLOT_LAST);
    end

`ifdef MUX_ARB_LOCK_EN
    assign locked = lock & owner_req;
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            sel_q    <= 2'd0;
            mux_en_n <= 1'b1;
            cnt      <= '0;
            last     <= 2'd3;
        end else begin
            case (state)
                IDLE, HANDOFF: begin
                    if (win_valid) begin
                        state    <= GRANT;
                        grant    <= 4'b0001 << win_idx;
                        sel_q    <= win_idx;
                        mux_en_n <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        state    <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req || (slot_end && others_pending && !locked)) begin
                        state    <= HANDOFF;
                        grant    <= 4'b0000;
                        mux_en_n <= 1'b1;
                        last     <= sel_q;
                    end else if (locked) begin
                        // Tenure is frozen at the last slot so expiry fires as soon as lock drops.
                        cnt      <= slot_end ? cnt : cnt + CNT_ONE;
                    end else if (slot_end) begin
                        cnt      <= '0;
                    end else begin
                        cnt      <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= 4'b0000;
                    mux_en_n <= 1'b1;
                end
            endcase
        end
    end

    assign mux_s1 = sel_q[1];
    assign mux_s0 = sel_q[0];
    assign busy   = (state == GRANT) || (state == HANDOFF);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a table of per-cycle vectors plus hand-written
// sequences for owner drop, mid-grant reset, handoff re-grant and (optionally) lock.
module tb_mux_rr_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [1:0] exp_sel;
        logic       exp_en_n;
        logic       exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       lock = 1'b0;
    logic [3:0] grant;
    logic       mux_s1;
    logic       mux_s0;
    logic       mux_en_n;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    vec_t vecs[64];
    int   nvec = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.SLOT_CYCLES(4), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
`ifdef MUX_ARB_LOCK_EN
        .lock     (lock),
`endif
        .grant    (grant),
        .mux_s1   (mux_s1),
        .mux_s0   (mux_s0),
        .mux_en_n (mux_en_n),
        .busy     (busy)
    );

    task automatic addVec(input logic r, input logic [3:0] q, input logic [3:0] g,
                          input logic [1:0] s, input logic en_n, input logic b);
        vecs[nvec].rst       = r;
        vecs[nvec].req       = q;
        vecs[nvec].exp_grant = g;
        vecs[nvec].exp_sel   = s;
        vecs[nvec].exp_en_n  = en_n;
        vecs[nvec].exp_busy  = b;
        nvec++;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic [3:0] q, input logic l);
        @(negedge clk);
        rst  = r;
        req  = q;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] g, input logic [1:0] s,
                               input logic en_n, input logic b);
        compared++;
        if (grant !== g || {mux_s1, mux_s0} !== s || mux_en_n !== en_n || busy !== b) begin
            mismatched++;
            $display("[TB] FAIL %s: got grant=%b sel=%b en_n=%b busy=%b, expected grant=%b sel=%b en_n=%b busy=%b",
                     name, grant, {mux_s1, mux_s0}, mux_en_n, busy, g, s, en_n, b);
        end
    endtask

    initial begin
        logic [3:0] onehot;
        logic [1:0] owner;

        // Reset, idle, sole requester 2 held for 20 cycles past its grant.
        addVec(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 4'b0100, 4'b0100, 2'b10, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            addVec(1'b0, 4'b0100, 4'b0100, 2'b10, 1'b0, 1'b1);
        // Full contention: reset wins over req, then 4-cycle slots split by 1-cycle handoffs.
        addVec(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            owner  = 2'(k);
            onehot = 4'b0001 << owner;
            for (int c = 0; c < 4; c++)
                addVec(1'b0, 4'b1111, onehot, owner, 1'b0, 1'b1);
            addVec(1'b0, 4'b1111, 4'b0000, owner, 1'b1, 1'b1);
        end

        for (int i = 0; i < nvec; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_sel,
                        vecs[i].exp_en_n, vecs[i].exp_busy);
        end

        // Owner 1 drops its request after two cycles while requester 3 waits.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b1010, 1'b0);
        checkOutput("drop_grant1_a", 4'b0010, 2'b01, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b1010, 1'b0);
        checkOutput("drop_grant1_b", 4'b0010, 2'b01, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b1000, 1'b0);
        checkOutput("drop_handoff", 4'b0000, 2'b01, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b1000, 1'b0);
        checkOutput("drop_grant3", 4'b1000, 2'b11, 1'b0, 1'b1);

        // Reset pulse in the middle of requester 2's tenure.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("midrst_grant2", 4'b0100, 2'b10, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkOutput("midrst_idle", 4'b0000, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0101, 1'b0);
        checkOutput("midrst_regrant0", 4'b0001, 2'b00, 1'b0, 1'b1);

        // Sole requester 0 re-wins when it reasserts during handoff; idle when nobody asks.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("sole_grant0", 4'b0001, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("sole_handoff", 4'b0000, 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("sole_regrant0", 4'b0001, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("sole_handoff2", 4'b0000, 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("sole_idle", 4'b0000, 2'b00, 1'b1, 1'b0);

`ifdef MUX_ARB_LOCK_EN
        // Owner 0 locks against requester 1 for 10 cycles, then releases.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("lock_grant0", 4'b0001, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'b0011, 1'b1);
            checkOutput($sformatf("lock_hold%0d", i), 4'b0001, 2'b00, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 4'b0011, 1'b0);
        checkOutput("lock_handoff", 4'b0000, 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        checkOutput("lock_grant1", 4'b0010, 2'b01, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
